// File: rtl/javk_bus_ctrl.sv
// JAVK external-bus cycle engine: one request of 1..BYTES bytes becomes
// a run of byte-wide bus cycles with fixed wait states and external stall.
module javk_bus_ctrl #(
   parameter int ADDR_W = 16,
   parameter int BYTES  = 2,
   parameter int WAIT   = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [$clog2(BYTES)-1:0]   req_len,
   input  logic [8*BYTES-1:0]         req_wdata,
   output logic                       rsp_valid,
   output logic [8*BYTES-1:0]         rsp_rdata,
   output logic [ADDR_W-1:0]          addrbus,
   output logic                       rw,
   output logic [7:0]                 bus_out,
   output logic                       bus_oe,
   input  logic [7:0]                 bus_in,
   input  logic                       bus_wait
);

   localparam int LW = $clog2(BYTES);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t               state;
   logic                 wr;
   logic [ADDR_W-1:0]    base;
   logic [LW-1:0]        len;
   logic [LW-1:0]        k;
   logic [LW-1:0]        k_nx;
   logic [8*BYTES-1:0]   wdata;
   logic [8*BYTES-1:0]   rdata;
   logic [8*BYTES-1:0]   rdata_nx;
   logic [3:0]           wcnt;

   assign req_ready = (state == IDLE);
   assign k_nx      = k + 1'b1;

   // Accumulator with the current byte merged in; writes leave it cleared.
   always_comb begin
      rdata_nx = rdata;
      if (!wr) rdata_nx[8*k +: 8] = bus_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addrbus   <= '0;
         rw        <= 1'b1;
         bus_oe    <= 1'b0;
         bus_out   <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         wr        <= 1'b0;
         base      <= '0;
         len       <= '0;
         k         <= '0;
         wdata     <= '0;
         rdata     <= '0;
         wcnt      <= 4'd0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  wr      <= req_write;
                  base    <= req_addr;
                  len     <= req_len;
                  wdata   <= req_wdata;
                  k       <= '0;
                  rdata   <= '0;
                  wcnt    <= 4'd0;
                  addrbus <= req_addr;
                  rw      <= ~req_write;
                  bus_oe  <= req_write;
                  bus_out <= req_wdata[7:0];
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               // bus_wait only matters once the fixed wait states are used up
               if (wcnt != 4'(WAIT)) begin
                  wcnt <= wcnt + 4'd1;
               end else if (!bus_wait) begin
                  wcnt  <= 4'd0;
                  rdata <= rdata_nx;
                  if (k == len) begin
                     state     <= RESP;
                     rw        <= 1'b1;
                     bus_oe    <= 1'b0;
                     bus_out   <= 8'h00;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rdata_nx;
                  end else begin
                     k       <= k_nx;
                     addrbus <= base + ADDR_W'(k_nx);
                     bus_out <= wdata[8*k_nx +: 8];
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_javk_bus_ctrl.sv
// Bench for javk_bus_ctrl: three instances with WAIT=0,1,2, a trace model
// expanded per request, and directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_javk_bus_ctrl;

   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [N];
   logic        req_valid [N];
   logic        req_ready [N];
   logic        req_write [N];
   logic [15:0] req_addr  [N];
   logic        req_len   [N];
   logic [15:0] req_wdata [N];
   logic        rsp_valid [N];
   logic [15:0] rsp_rdata [N];
   logic [15:0] addrbus   [N];
   logic        rw        [N];
   logic [7:0]  bus_out   [N];
   logic        bus_oe    [N];
   logic [7:0]  bus_in    [N];
   logic        bus_wait  [N];

   int stall [N][2];
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : lane
      javk_bus_ctrl #(.ADDR_W(16), .BYTES(2), .WAIT(g)) dut (
         .clk(clk), .rst(rst[g]),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_write(req_write[g]), .req_addr(req_addr[g]),
         .req_len(req_len[g]), .req_wdata(req_wdata[g]),
         .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
         .addrbus(addrbus[g]), .rw(rw[g]),
         .bus_out(bus_out[g]), .bus_oe(bus_oe[g]),
         .bus_in(bus_in[g]), .bus_wait(bus_wait[g])
      );
   end

   // Memory behind the pads.
   function automatic logic [7:0] memv(input logic [15:0] a);
      case (a)
         16'h1234: return 8'hAB;
         16'h1235: return 8'hCD;
         16'hFFFF: return 8'h11;
         16'h0000: return 8'h22;
         default:  return a[7:0] ^ a[15:8] ^ 8'h3C;
      endcase
   endfunction

   typedef struct {
      logic [15:0] a;
      logic        rw;
      logic        oe;
      logic [7:0]  o;
      logic        rv;
      logic [15:0] rd;
      logic        rdy;
      logic        wt;
      logic [7:0]  bi;
   } exp_t;

   function automatic exp_t idle_e(input logic [15:0] a, input logic [15:0] rd);
      exp_t e;
      e.a = a; e.rw = 1'b1; e.oe = 1'b0; e.o = 8'h00; e.rv = 1'b0;
      e.rd = rd; e.rdy = 1'b1; e.wt = 1'b0; e.bi = 8'h00;
      return e;
   endfunction

   exp_t        q      [N][$];
   exp_t        cur    [N];
   logic [15:0] last_a [N];
   logic [15:0] hold   [N];

   // Expand an accepted request into its expected per-clock trace.
   task automatic expand(input int g);
      exp_t e;
      logic [15:0] acc, ad;
      int n;
      acc = 16'h0;
      ad = req_addr[g];
      for (int k = 0; k <= int'(req_len[g]); k++) begin
         ad = req_addr[g] + 16'(k);
         n = g + 1 + stall[g][k];
         for (int c = 0; c < n; c++) begin
            e.a = ad; e.rw = !req_write[g]; e.oe = req_write[g];
            e.o = req_wdata[g][8*k +: 8]; e.rv = 1'b0; e.rd = hold[g];
            e.rdy = 1'b0; e.wt = (c != n - 1);
            e.bi = (c == n - 1) ? memv(ad) : ~memv(ad);
            q[g].push_back(e);
         end
         if (!req_write[g]) acc[8*k +: 8] = memv(ad);
      end
      hold[g] = req_write[g] ? 16'h0 : acc;
      last_a[g] = ad;
      e = idle_e(ad, hold[g]);
      e.rv = 1'b1;
      e.rdy = 1'b0;
      q[g].push_back(e);
   endtask

   initial begin : model
      for (int g = 0; g < N; g++) begin
         bus_wait[g] = 1'b0;
         bus_in[g] = 8'h00;
         last_a[g] = 16'h0;
         hold[g] = 16'h0;
         cur[g] = idle_e(16'h0, 16'h0);
      end
      forever begin
         @(posedge clk);
         for (int g = 0; g < N; g++) begin
            if (rst[g]) begin
               q[g].delete();
               last_a[g] = 16'h0;
               hold[g] = 16'h0;
               cur[g] = idle_e(16'h0, 16'h0);
            end else begin
               if (cur[g].rdy && req_valid[g]) expand(g);
               cur[g] = (q[g].size() > 0) ? q[g].pop_front()
                                          : idle_e(last_a[g], hold[g]);
            end
         end
         #1;
         for (int g = 0; g < N; g++) begin
            n_chk++;
            if ({addrbus[g], rw[g], bus_oe[g], bus_out[g], rsp_valid[g],
                 rsp_rdata[g], req_ready[g]} !==
                {cur[g].a, cur[g].rw, cur[g].oe, cur[g].o, cur[g].rv,
                 cur[g].rd, cur[g].rdy}) begin
               n_fail++;
               $display("FAIL lane%0d cyc%0d outputs: got a=%h rw=%b oe=%b o=%h rv=%b rd=%h rdy=%b, want a=%h rw=%b oe=%b o=%h rv=%b rd=%h rdy=%b",
                        g, cyc, addrbus[g], rw[g], bus_oe[g], bus_out[g],
                        rsp_valid[g], rsp_rdata[g], req_ready[g],
                        cur[g].a, cur[g].rw, cur[g].oe, cur[g].o,
                        cur[g].rv, cur[g].rd, cur[g].rdy);
            end
            bus_wait[g] = cur[g].wt;
            bus_in[g] = cur[g].bi;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   // Present a request and wait for its accept edge; c0 is cyc just after it.
   task automatic issue(input int g, input logic w, input logic [15:0] a,
                        input logic l, input logic [15:0] wd,
                        input int s0, input int s1, input bit keep,
                        output int c0);
      req_write[g] = w; req_addr[g] = a; req_len[g] = l; req_wdata[g] = wd;
      stall[g][0] = s0; stall[g][1] = s1;
      req_valid[g] = 1'b1;
      c0 = -1;
      for (int i = 0; i < 100; i++) begin
         if (req_ready[g]) begin
            @(posedge clk); #1;
            c0 = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      if (!keep) req_valid[g] = 1'b0;
      if (c0 < 0) begin
         n_chk++; n_fail++;
         $display("FAIL accept lane%0d: got timeout, want accept", g);
      end
   endtask

   // lat counts clocks from accept to the rsp_valid clock (clock 1 = first byte).
   task automatic wait_rsp(input int g, input int c0, input logic [15:0] a,
                           input logic [7:0] lo, input logic [7:0] hi,
                           output int lat, output logic [15:0] rd,
                           output int n_oe, output int n_lo,
                           output int n_hi, output int n_a);
      lat = -1; rd = 16'hxxxx; n_oe = 0; n_lo = 0; n_hi = 0; n_a = 0;
      for (int i = 0; i < 200; i++) begin
         if (rsp_valid[g]) begin
            lat = cyc - c0 + 1;
            rd = rsp_rdata[g];
            break;
         end
         if (!rw[g] && bus_oe[g]) n_oe++;
         if (bus_oe[g] && bus_out[g] == lo) n_lo++;
         if (bus_oe[g] && bus_out[g] == hi) n_hi++;
         if (addrbus[g] == a) n_a++;
         @(posedge clk); #1;
      end
      if (lat < 0) begin
         n_chk++; n_fail++;
         $display("FAIL rsp lane%0d: got timeout, want rsp_valid", g);
      end
   endtask

   initial begin : stim
      int c0, c2, lat, n_oe, n_lo, n_hi, n_a, rsp_c, n_low;
      logic [15:0] rd;
      for (int g = 0; g < N; g++) begin
         rst[g] = 1'b1; req_valid[g] = 1'b0; req_write[g] = 1'b0;
         req_addr[g] = 16'h0; req_len[g] = 1'b0; req_wdata[g] = 16'h0;
         stall[g][0] = 0; stall[g][1] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {addrbus[0], rw[0], bus_oe[0], bus_out[0],
                          rsp_valid[0], rsp_rdata[0], req_ready[0]},
          {16'h0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1});
      for (int g = 0; g < N; g++) rst[g] = 1'b0;
      @(posedge clk); #1;

      issue(0, 1'b0, 16'h1234, 1'b1, 16'h0, 0, 0, 0, c0);
      wait_rsp(0, c0, 16'h1234, 8'h00, 8'h00, lat, rd, n_oe, n_lo, n_hi, n_a);
      chk("rd_latency", lat, 3);
      chk("rd_data", rd, 16'hCDAB);
      chk("rd_addr0_clocks", n_a, 1);

      issue(2, 1'b1, 16'h0040, 1'b1, 16'h5AA5, 0, 0, 0, c0);
      wait_rsp(2, c0, 16'h0040, 8'hA5, 8'h5A, lat, rd, n_oe, n_lo, n_hi, n_a);
      chk("wr_oe_clocks", n_oe, 6);
      chk("wr_byte0_clocks", n_lo, 3);
      chk("wr_byte1_clocks", n_hi, 3);
      chk("wr_latency", lat, 7);
      chk("wr_rdata", rd, 16'h0);

      issue(0, 1'b0, 16'hFFFF, 1'b1, 16'h0, 0, 0, 0, c0);
      wait_rsp(0, c0, 16'hFFFF, 8'h00, 8'h00, lat, rd, n_oe, n_lo, n_hi, n_a);
      chk("wrap_latency", lat, 3);
      chk("wrap_data", rd, 16'h2211);

      issue(1, 1'b0, 16'h0100, 1'b0, 16'h0, 3, 0, 0, c0);
      wait_rsp(1, c0, 16'h0100, 8'h00, 8'h00, lat, rd, n_oe, n_lo, n_hi, n_a);
      chk("stall_latency", lat, 6);
      chk("stall_data", rd, 16'h003D);
      chk("stall_addr_clocks", n_a, 5);

      issue(1, 1'b1, 16'h00FF, 1'b1, 16'h1234, 0, 2, 0, c0);
      wait_rsp(1, c0, 16'h00FF, 8'h34, 8'h12, lat, rd, n_oe, n_lo, n_hi, n_a);
      chk("wstall_latency", lat, 7);
      chk("wstall_byte1_clocks", n_hi, 4);

      // Reset during the second byte of a write, with a request pending.
      issue(2, 1'b1, 16'h0040, 1'b1, 16'h5AA5, 0, 0, 0, c0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_pre_addr", addrbus[2], 16'h0041);
      rst[2] = 1'b1;
      req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 16'h0300;
      @(posedge clk); #1;
      chk("midrst_outputs", {bus_oe[2], rw[2], addrbus[2], req_ready[2],
                             rsp_valid[2]},
          {1'b0, 1'b1, 16'h0, 1'b1, 1'b0});
      rst[2] = 1'b0;
      req_valid[2] = 1'b0;
      issue(2, 1'b0, 16'h0040, 1'b0, 16'h0, 0, 0, 0, c0);
      wait_rsp(2, c0, 16'h0040, 8'h00, 8'h00, lat, rd, n_oe, n_lo, n_hi, n_a);
      chk("midrst_next_latency", lat, 4);
      chk("midrst_next_data", rd, 16'h007C);

      // req_valid held high across two requests.
      issue(0, 1'b0, 16'h2000, 1'b0, 16'h0, 0, 0, 1, c0);
      req_write[0] = 1'b1; req_addr[0] = 16'h2001;
      req_len[0] = 1'b1; req_wdata[0] = 16'hBEEF;
      rsp_c = -1; n_low = 0; c2 = -1;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid[0]) rsp_c = cyc;
         if (req_ready[0]) begin
            @(posedge clk); #1;
            c2 = cyc;
            break;
         end
         n_low++;
         @(posedge clk); #1;
      end
      req_valid[0] = 1'b0;
      chk("b2b_ready_low_clocks", n_low, 2);
      chk("b2b_accept_after_rsp", c2 - rsp_c, 2);
      wait_rsp(0, c2, 16'h2001, 8'hEF, 8'hBE, lat, rd, n_oe, n_lo, n_hi, n_a);
      chk("b2b_second_latency", lat, 3);
      chk("b2b_second_rdata", rd, 16'h0);

      repeat (4) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/javk_bus_ctrl.md
# javk_bus_ctrl

Parametrised external-bus cycle engine for the JAVK CPU. It sits between the core's execute/fetch logic and the 8-bit memory bus. It turns one request of 1..BYTES bytes into a sequence of byte-wide read or write bus cycles at consecutive addresses, with configurable fixed wait states plus an external stall input. It returns a single response when the transfer completes.

## Interface
- ADDR_W, 16, address bus width in bits.
- BYTES, 2, maximum bytes per request; power of two, ≥2.
- WAIT, 0, fixed wait states per byte cycle (0..15).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  address of byte 0.
- req_len  in  log2(BYTES)  byte count minus one.
- req_wdata  in  8*BYTES  write data; byte k in [8k+:8].
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  8*BYTES  read data; byte k in [8k+:8], bytes ≥ len+1 zero; zero for writes.
- addrbus  out  ADDR_W  bus address.
- rw  out  1  1 = read or idle, 0 = write.
- bus_out  out  8  write data to the pad tristate.
- bus_oe  out  1  drive enable for bus_out.
- bus_in  in  8  data from the pad.
- bus_wait  in  1  external stall; extends the current byte cycle.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - Capture write, addr, len, wdata.
  - Clear the rdata accumulator and byte index k=0.
  - Go to ACCESS.
- ACCESS: each byte cycle lasts WAIT+1 clocks minimum.
  - addrbus = req_addr+k modulo 2^ADDR_W; wraps 0xFFFF→0x0000 at ADDR_W=16.
  - rw = ~write.
  - bus_oe = write; bus_out = wdata byte k.
- Byte cycle end: the byte ends on the rising edge of its last clock if bus_wait=0 in that clock. Otherwise the cycle extends one clock per clock with bus_wait=1.
  - bus_wait is ignored in clocks before the last fixed clock.
- Read: bus_in is sampled into rdata byte k on the completing edge.
- At the completing edge: if k==len go to RESP, else k+1 and stay in ACCESS.
- RESP: rsp_valid=1 and rsp_rdata valid for exactly this cycle; bus released. Next state IDLE.
- Bus released (IDLE/RESP): rw=1, bus_oe=0, bus_out=0; addrbus holds its last value.
- rsp_rdata holds its value until the next RESP.
- Reset:
  - state IDLE; addrbus=0, rw=1, bus_oe=0, bus_out=0.
  - rsp_valid=0, rsp_rdata=0, req_ready=1.
  - Requests presented while rst=1 are ignored.
- Reset mid-transfer: aborts on that edge. No rsp_valid is issued, and the bus is released on the same edge.

## Timing
- All outputs are registered except req_ready, which decodes state.
- Accept at edge E0. Byte k occupies clocks E0+1+k(WAIT+1) .. E0+(k+1)(WAIT+1), without stalls.
- rsp_valid is high in the clock after the last byte completes.
- Latency from accept to rsp_valid: (len+1)(WAIT+1)+1 clocks, plus stall clocks.
- req_ready returns high in the clock after RESP. Minimum request spacing: (len+1)(WAIT+1)+2 clocks.
- Back-to-back bytes have no idle clock between them; addrbus changes on the completing edge.
- Write data and bus_oe are stable for the whole byte cycle, including stall clocks.

## Test plan
- Read, WAIT=0, addr 0x1234, len=1; bus returns 0xAB then 0xCD:
  - addrbus 0x1234 for 1 clock, then 0x1235 for 1 clock.
  - rsp_valid 3 clocks after accept; rsp_rdata=0xCDAB.
- Write, WAIT=2, addr 0x0040, len=1, wdata=0x5AA5:
  - rw=0 and bus_oe=1 for 6 clocks; bus_out 0xA5 for 3 clocks, then 0x5A for 3 clocks.
  - rsp_valid at clock 7; rsp_rdata=0.
- Wrap: read at 0xFFFF, len=1 → addrbus 0xFFFF then 0x0000; both bytes captured.
- Stall: WAIT=1, single-byte read, bus_wait high for 3 clocks in the byte's last clock:
  - byte cycle lasts 5 clocks; data is sampled on the edge after bus_wait drops.
  - rsp_valid at clock 6.
- Reset mid-write at byte 1 → next edge gives bus_oe=0, rw=1, addrbus=0, req_ready=1, and no rsp_valid. A new request is then accepted normally.
- req_valid held high continuously:
  - req_ready is low throughout ACCESS and RESP.
  - The second request is accepted exactly one clock after rsp_valid.
